// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one byte-wide external RAM between instruction fetch (IF, word reads)
// and the MEM stage (byte/half/word loads and stores selected by a 4-bit lane
// mask). Each granted request is split into one RAM cycle per enabled lane,
// with lanes issued in ascending order. Read bytes are assembled into a 32-bit
// word. The requester then gets a one-cycle done pulse.
//
// Lane i covers byte address {addr[31:2],2'b00}+i and data bits
// [31-8i:24-8i], so lane 0 is the most significant byte.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   if_req_i        IF word-read request (level, held until if_done_o)
//   if_addr_i       IF word address (bits [1:0] ignored)
//   if_data_o       fetched word, non-zero only during the IF done pulse
//   if_done_o       one-cycle IF completion pulse
//   mem_ce_i        MEM request (level, held until mem_done_o), wins over IF
//   mem_we_i        1 = store, 0 = load
//   mem_addr_i      MEM address (bits [1:0] ignored)
//   mem_sel_i       lane enables
//   mem_data_i      lane-mapped store data
//   mem_data_o      lane-mapped load data, non-zero only during the MEM done pulse
//   mem_done_o      one-cycle MEM completion pulse
//   stall_req_o     mem_ce_i & ~mem_done_o (held low while in reset)
//   ram_a_o         RAM byte address (low RAM_AW bits)
//   ram_wr_o        RAM write strobe
//   ram_dout_o      RAM write data
//   ram_din_i       RAM read data, valid one cycle after its address
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_done_o,
  output logic              stall_req_o,
  output logic [RAM_AW-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_t;

  // Byte of a word that belongs to a lane (lane 0 is the MSB).
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      2'd3:    b = w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Returns w with the byte of the given lane replaced by b.
  function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (lane)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      2'd3:    r[7:0]   = b;
      default: r        = w;
    endcase
    return r;
  endfunction

  // Lowest enabled lane at or above start: {found, lane}. A start of 4 finds nothing.
  function automatic logic [2:0] lane_search(input logic [3:0] sel, input logic [2:0] start);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if ((i >= int'(start)) && sel[i]) begin
        r = {1'b1, 2'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  state_t             state_r, state_n;
  logic [1:0]         ptr_r, ptr_n;
  logic [1:0]         prev_ptr_r, prev_ptr_n;
  logic               first_r, first_n;
  logic               owner_mem_r, owner_mem_n;
  logic               we_r, we_n;
  logic [RAM_AW-3:0]  word_r, word_n;
  logic [3:0]         sel_r, sel_n;
  logic [31:0]        wdata_r, wdata_n;
  logic [31:0]        rdata_r, rdata_n;
  logic               if_done_r, if_done_n;
  logic               mem_done_r, mem_done_n;
  logic [31:0]        if_data_r, if_data_n;
  logic [31:0]        mem_data_r, mem_data_n;

  logic               pulse_s;
  logic               gnt_s;
  logic               gnt_mem_s;
  logic [3:0]         gnt_sel_s;
  logic [2:0]         gnt_lane_s;
  logic [2:0]         nxt_lane_s;
  logic               unused_s;

  // Low address bits are lane offsets and the high bits lie outside the RAM.
  assign unused_s = ^{if_addr_i, mem_addr_i};

  // The done pulse is a registered output, so the IDLE cycle that carries it
  // must not sample: the finished requester is still allowed to hold its request.
  assign pulse_s    = if_done_r | mem_done_r;
  assign gnt_s      = ~pulse_s & (mem_ce_i | if_req_i);
  assign gnt_mem_s  = mem_ce_i;
  assign gnt_sel_s  = mem_ce_i ? mem_sel_i : 4'b1111;
  assign gnt_lane_s = lane_search(gnt_sel_s, 3'd0);
  assign nxt_lane_s = lane_search(sel_r, {1'b0, ptr_r} + 3'd1);

  // Outputs seen by the pipeline; stall is forced low while in reset.
  assign if_done_o   = if_done_r;
  assign if_data_o   = if_data_r;
  assign mem_done_o  = mem_done_r;
  assign mem_data_o  = mem_data_r;
  assign stall_req_o = rst & mem_ce_i & ~mem_done_r;

  // State and datapath registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      ptr_r       <= 2'd0;
      prev_ptr_r  <= 2'd0;
      first_r     <= 1'b0;
      owner_mem_r <= 1'b0;
      we_r        <= 1'b0;
      word_r      <= {(RAM_AW-2){1'b0}};
      sel_r       <= 4'b0000;
      wdata_r     <= 32'h0;
      rdata_r     <= 32'h0;
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      if_data_r   <= 32'h0;
      mem_data_r  <= 32'h0;
    end else begin
      state_r     <= state_n;
      ptr_r       <= ptr_n;
      prev_ptr_r  <= prev_ptr_n;
      first_r     <= first_n;
      owner_mem_r <= owner_mem_n;
      we_r        <= we_n;
      word_r      <= word_n;
      sel_r       <= sel_n;
      wdata_r     <= wdata_n;
      rdata_r     <= rdata_n;
      if_done_r   <= if_done_n;
      mem_done_r  <= mem_done_n;
      if_data_r   <= if_data_n;
      mem_data_r  <= mem_data_n;
    end
  end

  // Next-state logic: grant, per-lane sequencing, read capture and completion.
  always_comb begin
    state_n     = state_r;
    ptr_n       = ptr_r;
    prev_ptr_n  = prev_ptr_r;
    first_n     = first_r;
    owner_mem_n = owner_mem_r;
    we_n        = we_r;
    word_n      = word_r;
    sel_n       = sel_r;
    wdata_n     = wdata_r;
    rdata_n     = rdata_r;
    if_done_n   = 1'b0;
    mem_done_n  = 1'b0;
    if_data_n   = 32'h0;
    mem_data_n  = 32'h0;
    case (state_r)
      IDLE: begin
        if (gnt_s) begin
          owner_mem_n = gnt_mem_s;
          we_n        = gnt_mem_s ? mem_we_i : 1'b0;
          word_n      = gnt_mem_s ? mem_addr_i[RAM_AW-1:2] : if_addr_i[RAM_AW-1:2];
          sel_n       = gnt_sel_s;
          wdata_n     = gnt_mem_s ? mem_data_i : 32'h0;
          rdata_n     = 32'h0;
          first_n     = 1'b1;
          if (gnt_lane_s[2]) begin
            state_n = XFER;
            ptr_n   = gnt_lane_s[1:0];
          end else begin
            state_n = DONE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      XFER: begin
        // Read data lags its address by one cycle, so it belongs to the previous lane.
        if (!we_r && !first_r) begin
          rdata_n = put_lane(rdata_r, prev_ptr_r, ram_din_i);
        end else begin
          rdata_n = rdata_r;
        end
        prev_ptr_n = ptr_r;
        first_n    = 1'b0;
        if (nxt_lane_s[2]) begin
          ptr_n = nxt_lane_s[1:0];
        end else if (we_r) begin
          state_n = DONE;
        end else begin
          state_n = TAIL;
        end
      end
      TAIL: begin
        rdata_n = put_lane(rdata_r, prev_ptr_r, ram_din_i);
        state_n = DONE;
      end
      DONE: begin
        if (owner_mem_r) begin
          mem_done_n = 1'b1;
          mem_data_n = rdata_r;
        end else begin
          if_done_n = 1'b1;
          if_data_n = rdata_r;
        end
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // RAM side: driven from registered state only and idle (all zero) outside XFER.
  always_comb begin
    ram_a_o    = {RAM_AW{1'b0}};
    ram_wr_o   = 1'b0;
    ram_dout_o = 8'h00;
    if (state_r == XFER) begin
      ram_a_o = {word_r, ptr_r};
      if (we_r) begin
        ram_wr_o   = 1'b1;
        ram_dout_o = lane_byte(wdata_r, ptr_r);
      end else begin
        ram_wr_o   = 1'b0;
        ram_dout_o = 8'h00;
      end
    end else begin
      ram_a_o = {RAM_AW{1'b0}};
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide external RAM between two requesters: instruction fetch (IF, read-only word) and the MEM stage (byte/half/word loads and stores, qualified by a 4-bit lane select).
- Serialises each request into per-byte RAM cycles and assembles read data into a 32-bit word.
- Returns a one-cycle done pulse to the requester and raises a pipeline stall request while a MEM access is outstanding.

Parameters:
RAM_AW, 17, width of the external RAM byte address; ram_a_o carries the low RAM_AW bits of the byte address.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
if_req_i  in  1  IF word-read request, level, held until if_done_o
if_addr_i  in  32  IF word address, bits [1:0] ignored
if_data_o  out  32  fetched word, valid while if_done_o high
if_done_o  out  1  one-cycle completion pulse for IF
mem_ce_i  in  1  MEM request, level, held until mem_done_o
mem_we_i  in  1  1 = store, 0 = load
mem_addr_i  in  32  MEM address, bits [1:0] ignored
mem_sel_i  in  4  lane enables
mem_data_i  in  32  store data, lane-mapped
mem_data_o  out  32  load data, lane-mapped, unselected lanes 0, valid while mem_done_o high
mem_done_o  out  1  one-cycle completion pulse for MEM
stall_req_o  out  1  mem_ce_i & ~mem_done_o (combinational)
ram_a_o  out  RAM_AW  RAM byte address
ram_wr_o  out  1  RAM write strobe
ram_dout_o  out  8  RAM write data
ram_din_i  in  8  RAM read data, valid one cycle after its address is driven

Behaviour:
- Reset: rst low asynchronously forces state IDLE. All outputs are 0 while in reset and on release.
- Lane mapping:
  - Lane i (sel bit i) has byte address {addr[31:2],2'b00}+i.
  - Lane i occupies data bits [31-8i:24-8i]; lane 0 is [31:24].
  - IF always uses sel 4'b1111.
- States:
  - IDLE
  - XFER (2-bit lane pointer)
  - TAIL (capture last read byte)
  - DONE
- IDLE:
  - At each clock edge, sample requests. mem_ce_i has priority over if_req_i.
  - The edge at which a request is taken is the grant edge G.
  - Latch owner, we, word address, sel and store data; clear the read-assembly register.
  - Let n be the number of set sel bits. If n = 0, go to DONE. Otherwise go to XFER with the pointer at the lowest set lane.
- XFER, one cycle per enabled lane, lanes ascending, unselected lanes skipped:
  - Drive ram_a_o = lane address. For stores, ram_wr_o = 1 and ram_dout_o = latched lane byte.
  - For loads, capture ram_din_i into the lane register of the previously issued lane (none in the first XFER cycle).
  - After the last enabled lane, go to TAIL for loads or DONE for stores.
- TAIL (loads only): capture ram_din_i into the last lane; ram_wr_o = 0; go to DONE.
- DONE:
  - Pulse the owner's done output for one cycle and present the assembled word on its data output; go to IDLE.
  - Requests are not sampled in DONE, so a requester may change its request on the done edge.
- Latency, measured from grant edge G:
  - Done is high in the cycle after edge G+n+1 for stores and G+n+2 for loads.
  - For n = 0, done is high in the cycle after G+1.
  - Example: IF word fetch, done after G+6. Example: SB, done after G+2.
- Outputs:
  - ram_a_o, ram_wr_o and ram_dout_o derive only from registered state. Outside XFER they are 0.
  - if_data_o and mem_data_o are 0 except in their owner's DONE cycle.
- Simultaneous requests: MEM is served first. IF stays pending and is granted in the IDLE cycle after MEM completes, unless mem_ce_i is high again then.
- A request is non-preemptible once granted:
  - A requester deasserting mid-transaction is illegal.
  - The controller still completes the transaction and pulses done.
- Address changes while owned are ignored because the address is latched at G.
- rst asserted mid-transaction aborts immediately to IDLE. Bytes already written remain in RAM; no done pulse is issued.

Test Plan:
1. RAM[0x100..0x103] = 13,05,00,00; if_req_i, if_addr_i = 0x100 -> ram_a_o 100,101,102,103 on consecutive cycles, ram_wr_o = 0, if_data_o = 0x13050000 with if_done_o one cycle after G+6.
2. SB: mem_addr_i = 0x203, sel = 4'b1000, mem_data_i = 0xABABABAB, we = 1 -> single cycle with ram_a_o = 0x203, ram_dout_o = 0xAB, ram_wr_o = 1; mem_done_o after G+2; stall_req_o high from request until done.
3. LH: addr 0x302, sel = 4'b1100, RAM[0x302] = 0x34, RAM[0x303] = 0x12 -> mem_data_o = 0x00003412, done after G+4.
4. if_req_i and mem_ce_i (LW at 0x400) rise in the same cycle -> MEM bytes issued first, mem_done_o after G+6; IF granted on the next IDLE edge, if_done_o 6 cycles later.
5. mem_ce_i with sel = 4'b0000 -> no RAM cycle, ram_wr_o stays 0, mem_done_o after G+1, mem_data_o = 0.
6. rst low during the second byte of an SW -> all outputs 0 immediately; after release, an IF fetch completes with normal timing.
